// File: rtl/mitchell_mult_sequencer.sv
// Approximate 8x8 unsigned multiplier built on one time-shared Mitchell log
// encoder: encode A, encode B, add the logs, then take the antilog.
module mitchell_mult_sequencer #(
    parameter bit ZERO_BYPASS = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        zero,
    output logic        busy
);

    localparam int unsigned OP_W    = 8;
    localparam int unsigned K_W     = 3;
    localparam int unsigned FRAC_W  = 7;
    localparam int unsigned LOG_W   = K_W + FRAC_W;
    localparam int unsigned SUM_W   = LOG_W + 1;
    localparam int unsigned PROD_W  = 16;
    localparam int unsigned ENC_W   = OP_W + FRAC_W;
    localparam int unsigned ANT_W   = (FRAC_W + 1) + 15;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENC_A   = 3'd1,
        ENC_B   = 3'd2,
        ADD     = 3'd3,
        ANTILOG = 3'd4,
        DONE    = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic [LOG_W-1:0]  log_a;
    logic [LOG_W-1:0]  log_b;
    logic [SUM_W-1:0]  lsum;

    logic [OP_W-1:0]   enc_in;
    logic [K_W-1:0]    enc_k;
    logic [ENC_W-1:0]  enc_shift;
    logic [LOG_W-1:0]  enc_log;

    logic [ANT_W-1:0]  ant_shift;
    logic [PROD_W-1:0] ant_val;

    logic              zero_in;
    logic              latch_ops;
    logic              load_log_a;
    logic              load_log_b;
    logic              load_sum;
    logic              load_prod;
    logic              clear_prod;

    // Encoder operand mux; opA is the idle hold value.
    always_comb begin
        enc_in = (state_q == ENC_B) ? op_b : op_a;
    end

    // Shared Mitchell encoder: leading-one index plus left-justified remainder.
    always_comb begin
        enc_k = '0;
        for (int unsigned i = 0; i < OP_W; i++) begin
            if (enc_in[i]) begin
                enc_k = K_W'(i);
            end
        end
        enc_shift = (ENC_W'(enc_in) << FRAC_W) >> enc_k;
        enc_log   = {enc_k, enc_shift[FRAC_W-1:0]};
    end

    // Antilog of the summed logs; wide intermediate keeps K=15 from overflowing.
    always_comb begin
        ant_shift = (ANT_W'({1'b1, lsum[FRAC_W-1:0]}) << lsum[SUM_W-1:FRAC_W]) >> FRAC_W;
        ant_val   = ant_shift[PROD_W-1:0];
    end

    assign zero_in = (a == '0) | (b == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath load enables.
    always_comb begin
        state_d    = state_q;
        latch_ops  = 1'b0;
        load_log_a = 1'b0;
        load_log_b = 1'b0;
        load_sum   = 1'b0;
        load_prod  = 1'b0;
        clear_prod = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    latch_ops = 1'b1;
                    if (ZERO_BYPASS && zero_in) begin
                        clear_prod = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d    = ENC_A;
                    end
                end
            end
            ENC_A: begin
                load_log_a = 1'b1;
                state_d    = ENC_B;
            end
            ENC_B: begin
                load_log_b = 1'b1;
                state_d    = ADD;
            end
            ADD: begin
                load_sum = 1'b1;
                state_d  = ANTILOG;
            end
            ANTILOG: begin
                load_prod = 1'b1;
                state_d   = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand, log and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a    <= '0;
            op_b    <= '0;
            log_a   <= '0;
            log_b   <= '0;
            lsum    <= '0;
            product <= '0;
            zero    <= 1'b0;
        end else begin
            if (latch_ops) begin
                op_a <= a;
                op_b <= b;
                zero <= zero_in;
            end
            if (load_log_a) begin
                log_a <= enc_log;
            end
            if (load_log_b) begin
                log_b <= enc_log;
            end
            if (load_sum) begin
                lsum <= SUM_W'({1'b0, log_a}) + SUM_W'({1'b0, log_b});
            end
            if (clear_prod) begin
                product <= '0;
            end else if (load_prod) begin
                product <= zero ? '0 : ant_val;
            end
        end
    end

    // Handshake and status flags, registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            in_ready  <= (state_d == IDLE);
            out_valid <= (state_d == DONE);
            busy      <= (state_d != IDLE);
        end
    end

endmodule

// File: tb/tb_mitchell_mult_sequencer.sv
// Directed bench for mitchell_mult_sequencer, with and without zero bypass.
module tb_mitchell_mult_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  a;
    logic [7:0]  b;

    logic        in_valid1, in_ready1, out_valid1, out_ready1, zero1, busy1;
    logic [15:0] product1;
    logic        in_valid2, in_ready2, out_valid2, out_ready2, zero2, busy2;
    logic [15:0] product2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mitchell_mult_sequencer #(.ZERO_BYPASS(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready1),
        .product(product1), .zero(zero1), .busy(busy1)
    );

    mitchell_mult_sequencer #(.ZERO_BYPASS(1'b1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a), .b(b), .out_valid(out_valid2), .out_ready(out_ready2),
        .product(product2), .zero(zero2), .busy(busy2)
    );

    // Reference: log = k*128 + floor(remainder*128/2^k); antilog by multiply.
    function automatic logic [15:0] mitchell_ref(input logic [7:0] x, input logic [7:0] y);
        int kx, ky, fx, fy, s, kk, ff;
        longint p;
        if (x == 0 || y == 0) return 16'd0;
        kx = 0;
        ky = 0;
        for (int i = 0; i < 8; i++) begin
            if (x[i]) kx = i;
            if (y[i]) ky = i;
        end
        fx = ((int'(x) - (1 << kx)) * 128) / (1 << kx);
        fy = ((int'(y) - (1 << ky)) * 128) / (1 << ky);
        s  = kx * 128 + fx + ky * 128 + fy;
        kk = s / 128;
        ff = s % 128;
        p  = (longint'(128 + ff) * (longint'(1) << kk)) / 128;
        return 16'(p);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
        out_ready1 = 1'b1; out_ready2 = 1'b1; a = 8'd0; b = 8'd0;
        step(); step();
        rst_n = 1'b1;
        step();
        total++; if (out_valid1 !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid1); end
        total++; if (product1 !== 16'd0) begin bad++; $display("FAIL reset_product: got %0d want 0", product1); end
        total++; if (zero1 !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", zero1); end
        total++; if (busy1 !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy1); end
        total++; if (in_ready1 !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready1); end
        total++; if ({in_ready2, busy2, out_valid2} !== 3'b100) begin bad++; $display("FAIL reset_bypass_flags: got %b want 100", {in_ready2, busy2, out_valid2}); end
    endtask

    // One transaction on the selected instance (0: no bypass, 1: bypass).
    task automatic run_op(input logic sel, input logic [7:0] ta, input logic [7:0] tb_v,
                          input logic [15:0] exp_p, input logic exp_z, input int exp_lat,
                          input string name);
        int lat;
        a = ta; b = tb_v;
        if (sel) begin in_valid2 = 1'b1; out_ready2 = 1'b1; end
        else     begin in_valid1 = 1'b1; out_ready1 = 1'b1; end
        step();
        in_valid1 = 1'b0; in_valid2 = 1'b0;
        lat = 1;
        while (!(sel ? out_valid2 : out_valid1) && lat < 20) begin
            step();
            lat++;
        end
        total++; if (lat != exp_lat) begin bad++; $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat); end
        total++; if ((sel ? product2 : product1) !== exp_p) begin bad++; $display("FAIL %s_product: got %0d want %0d", name, sel ? product2 : product1, exp_p); end
        total++; if ((sel ? zero2 : zero1) !== exp_z) begin bad++; $display("FAIL %s_zero: got %b want %b", name, sel ? zero2 : zero1, exp_z); end
        step();
        total++; if ((sel ? {out_valid2, in_ready2} : {out_valid1, in_ready1}) !== 2'b01) begin
            bad++; $display("FAIL %s_return_idle: got %b want 01", name, sel ? {out_valid2, in_ready2} : {out_valid1, in_ready1});
        end
    endtask

    task automatic test_basic();
        run_op(1'b0, 8'd3,   8'd3,   16'd8,     1'b0, 5, "mul_3x3");
        run_op(1'b0, 8'd255, 8'd255, 16'd65024, 1'b0, 5, "mul_255x255");
        run_op(1'b0, 8'd12,  8'd10,  16'd112,   1'b0, 5, "mul_12x10");
        run_op(1'b0, 8'd1,   8'd200, 16'd200,   1'b0, 5, "mul_1x200");
        run_op(1'b0, 8'd16,  8'd13,  16'd208,   1'b0, 5, "mul_16x13");
    endtask

    task automatic test_zero();
        run_op(1'b0, 8'd0,  8'd77, 16'd0, 1'b1, 5, "zero_nobypass");
        run_op(1'b1, 8'd0,  8'd77, 16'd0, 1'b1, 1, "zero_bypass");
        run_op(1'b1, 8'd3,  8'd3,  16'd8, 1'b0, 5, "bypass_nonzero");
        run_op(1'b1, 8'd45, 8'd0,  16'd0, 1'b1, 1, "zero_bypass_b");
    endtask

    task automatic test_backpressure();
        int lat;
        a = 8'd5; b = 8'd6; in_valid1 = 1'b1; out_ready1 = 1'b0;
        step();
        in_valid1 = 1'b0;
        lat = 1;
        while (!out_valid1 && lat < 20) begin step(); lat++; end
        total++; if (lat != 5) begin bad++; $display("FAIL bp_latency: got %0d want 5", lat); end
        for (int i = 0; i < 10; i++) begin
            in_valid1 = i[0]; a = 8'(i + 1); b = 8'(i + 9);
            step();
            total++; if ({out_valid1, in_ready1, busy1, zero1} !== 4'b1010 || product1 !== 16'd28) begin
                bad++; $display("FAIL bp_hold_%0d: got flags=%b product=%0d want flags=1010 product=28", i, {out_valid1, in_ready1, busy1, zero1}, product1);
            end
        end
        in_valid1 = 1'b0; out_ready1 = 1'b1;
        step();
        total++; if ({out_valid1, in_ready1, busy1} !== 3'b010 || product1 !== 16'd28) begin
            bad++; $display("FAIL bp_release: got flags=%b product=%0d want flags=010 product=28", {out_valid1, in_ready1, busy1}, product1);
        end
        step(); step();
        total++; if ({out_valid1, busy1} !== 2'b00) begin bad++; $display("FAIL bp_single_handshake: got %b want 00", {out_valid1, busy1}); end
        run_op(1'b0, 8'd12, 8'd10, 16'd112, 1'b0, 5, "bp_next_pair");
    endtask

    task automatic test_reset_mid();
        int stray;
        a = 8'd200; b = 8'd100; in_valid1 = 1'b1; out_ready1 = 1'b1;
        step();
        in_valid1 = 1'b0;
        step();
        total++; if (busy1 !== 1'b1) begin bad++; $display("FAIL midrst_busy_before: got %b want 1", busy1); end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        total++; if ({out_valid1, in_ready1, busy1, zero1} !== 4'b0100 || product1 !== 16'd0) begin
            bad++; $display("FAIL midrst_state: got flags=%b product=%0d want flags=0100 product=0", {out_valid1, in_ready1, busy1, zero1}, product1);
        end
        stray = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid1 || busy1) stray++;
        end
        total++; if (stray != 0) begin bad++; $display("FAIL midrst_stale: got %0d active cycles want 0", stray); end
    endtask

    task automatic test_back_to_back();
        localparam int N = 10;
        logic [7:0]  pa [N];
        logic [7:0]  pb [N];
        logic [15:0] expq [$];
        logic [15:0] e;
        int sent, got, last, cyc;
        for (int i = 0; i < N; i++) begin
            pa[i] = 8'($urandom_range(0, 255));
            pb[i] = 8'($urandom_range(1, 255));
        end
        pa[1] = 8'd255; pb[1] = 8'd255;
        sent = 0; got = 0; last = -1;
        out_ready1 = 1'b1;
        for (cyc = 0; cyc < 200 && got < N; cyc++) begin
            if (out_valid1) begin
                e = (expq.size() > 0) ? expq.pop_front() : 16'hxxxx;
                total++; if (product1 !== e) begin bad++; $display("FAIL b2b_product_%0d: got %0d want %0d", got, product1, e); end
                if (last >= 0) begin
                    total++; if (cyc - last != 6) begin bad++; $display("FAIL b2b_spacing_%0d: got %0d want 6", got, cyc - last); end
                end
                last = cyc;
                got++;
            end
            if (in_ready1) begin
                if (sent < N) begin
                    a = pa[sent]; b = pb[sent]; in_valid1 = 1'b1;
                    expq.push_back(mitchell_ref(pa[sent], pb[sent]));
                    sent++;
                end else begin
                    in_valid1 = 1'b0;
                end
            end
            step();
        end
        in_valid1 = 1'b0;
        total++; if (got != N) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mitchell_mult_sequencer.md
Name: mitchell_mult_sequencer

Overview:
- Sequences one shared 8-bit Mitchell log encoder to form an approximate 8x8 -> 16-bit unsigned product.
- Operand A and operand B are encoded one after the other through the single encoder instance, which is time-multiplexed. The two logs are then summed and the sum is converted back to linear (antilog).
- Sits between an operand source and a result sink. Both sides use valid/ready handshakes.

Parameters:
- ZERO_BYPASS, 0: when 1, an accepted pair with a zero operand skips the encode, add and antilog states and goes straight to DONE. When 0, latency is fixed regardless of operand values.

Ports:
- clk  input  1  clock; all state changes on the rising edge
- rst_n  input  1  synchronous reset, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept a pair; high only in IDLE
- a  input  8  operand A, unsigned
- b  input  8  operand B, unsigned
- out_valid  output  1  product valid; high only in DONE
- out_ready  input  1  sink accepts product
- product  output  16  approximate A*B
- zero  output  1  accepted pair had A==0 or B==0
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is synchronous and active-low. While rst_n is low at a clk edge:
  - state goes to IDLE;
  - out_valid=0, product=0, zero=0, busy=0, in_ready=1 after the edge;
  - all internal registers (opA, opB, logA, logB, lsum) are cleared.
- Reset asserted mid-operation abandons the operation. No output is produced for it.
- Log format (encoder output, 10 bits) is {k[2:0], f[6:0]}:
  - k = index of the leading one;
  - f = the bits below the leading one, left-justified, truncated to 7 bits.
  - Example: 12 -> k=3, f=1000000.
  - The encoder output for input 0 is don't-care.
- The encoder input is driven by a 2:1 mux:
  - opA in ENC_A;
  - opB in ENC_B;
  - opA in all other states (hold value, no functional effect).
- FSM states: IDLE, ENC_A, ENC_B, ADD, ANTILOG, DONE.
  - IDLE: in_ready=1. If in_valid, latch a->opA and b->opB, latch zero=(a==0)|(b==0), and go to ENC_A. If ZERO_BYPASS=1 and the latched zero is 1, go to DONE instead with product=0.
  - ENC_A: logA <= encoder output; go to ENC_B.
  - ENC_B: logB <= encoder output; go to ADD.
  - ADD: lsum[10:0] <= {1'b0,logA} + {1'b0,logB}. The 11-bit sum is K=lsum[10:7] (0..15) and F=lsum[6:0]. A fraction carry propagates into K, which implements Mitchell's correction case. Go to ANTILOG.
  - ANTILOG: product <= zero ? 0 : (({1'b1,F} << K) >> 7), computed at 16 bits; bits shifted out below bit 0 are truncated. Go to DONE.
  - DONE: out_valid=1, with product and zero held stable. On out_ready=1, go to IDLE (out_valid=0 next cycle).
- Latency with ZERO_BYPASS=0: the accept edge is cycle 0 and out_valid is high from cycle 5 (after the ENC_A, ENC_B, ADD and ANTILOG edges).
- Throughput: one product per 6 cycles with out_ready held high.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.
- in_ready is low in DONE, so a new pair cannot be accepted in the same cycle the result is taken.
- Backpressure: DONE is held indefinitely while out_ready=0. product, zero and out_valid must not change during this time.
- in_valid while busy is ignored. The operands are not sampled and the upstream source must hold them.
- product bounds: maximum 65024 (A=B=255). product is exact when either operand is a power of two.

Test Plan:
- Reset, then a=3, b=3, one-cycle in_valid, out_ready=1 -> out_valid rises 5 cycles after accept, product=8, zero=0; back in IDLE with in_ready=1 on the next cycle.
- a=255, b=255 -> product=65024; a=12, b=10 -> product=112; a=1, b=200 -> product=200.
- a=0, b=77 with ZERO_BYPASS=0 -> product=0, zero=1, same 5-cycle latency. With ZERO_BYPASS=1 -> out_valid 1 cycle after accept, product=0.
- out_ready held 0 for 10 cycles in DONE, and in_valid toggled with new operands during it -> product, zero and out_valid are stable; in_ready=0; no new pair is accepted. Releasing out_ready -> exactly one handshake, then the next pair is accepted.
- rst_n pulsed low for one cycle while in ENC_B -> IDLE on the next cycle, out_valid=0, product=0, in_ready=1; no stale result appears later.
- Back-to-back random pairs with in_valid and out_ready held high -> every product matches a bit-exact Mitchell reference model; one result per 6 cycles.
